// File: rtl/move_entry_display.sv
// PS/2 make-code chess move entry with seven-segment echo; edits land one cycle after the strobe, display one more.
// A completed move is held on move_out until move_ack; all make codes are dropped while it waits.
module move_entry_display #(
  parameter int DIGITS     = 4,
  parameter int BLINK_BITS = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  code_valid,
  input  logic [7:0]            code,
  output logic                  move_ready,
  input  logic                  move_ack,
  output logic [4*DIGITS-1:0]   move_out,
  output logic                  entry_err,
  output logic [7*DIGITS-1:0]   seg_out
);

  localparam int         CW         = $clog2(DIGITS + 1);
  localparam logic [6:0] SEG_CURSOR = 7'b1110111;

  typedef enum logic [1:0] {IDLE, BREAK, EXT} filt_t;
  typedef struct packed {
    logic       is_rank;
    logic [2:0] idx;
  } char_t;

  filt_t                  state_q, state_d;
  logic                   make_vld;
  logic [CW-1:0]          count_q;
  char_t [DIGITS-1:0]     buf_q;
  logic [BLINK_BITS-1:0]  blink_q;
  logic [4:0]             dec;
  logic                   is_char;
  char_t                  key;
  logic                   full;
  logic [7*DIGITS-1:0]    seg_d;

  function automatic logic [6:0] glyph(input char_t c);
    logic [6:0] g;
    case ({c.is_rank, c.idx})
      4'h0:    g = 7'b0001000;
      4'h1:    g = 7'b0000011;
      4'h2:    g = 7'b1000110;
      4'h3:    g = 7'b0100001;
      4'h4:    g = 7'b0000110;
      4'h5:    g = 7'b0001110;
      4'h6:    g = 7'b0010000;
      4'h7:    g = 7'b0001001;
      4'h8:    g = 7'b1111001;
      4'h9:    g = 7'b0100100;
      4'hA:    g = 7'b0110000;
      4'hB:    g = 7'b0011001;
      4'hC:    g = 7'b0010010;
      4'hD:    g = 7'b0000010;
      4'hE:    g = 7'b1111000;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  // dec = {is_char, is_rank, idx}
  always_comb begin
    dec = 5'h00;
    case (code)
      8'h1C: dec = 5'h10;
      8'h32: dec = 5'h11;
      8'h21: dec = 5'h12;
      8'h23: dec = 5'h13;
      8'h24: dec = 5'h14;
      8'h2B: dec = 5'h15;
      8'h34: dec = 5'h16;
      8'h33: dec = 5'h17;
      8'h16: dec = 5'h18;
      8'h1E: dec = 5'h19;
      8'h26: dec = 5'h1A;
      8'h25: dec = 5'h1B;
      8'h2E: dec = 5'h1C;
      8'h36: dec = 5'h1D;
      8'h3D: dec = 5'h1E;
      8'h3E: dec = 5'h1F;
      default: dec = 5'h00;
    endcase
  end

  assign is_char = dec[4];
  assign key     = char_t'(dec[3:0]);
  assign full    = (count_q == CW'(DIGITS));

  always_comb begin
    state_d  = state_q;
    make_vld = 1'b0;
    if (code_valid) begin
      case (state_q)
        IDLE: begin
          if (code == 8'hF0)      state_d = BREAK;
          else if (code == 8'hE0) state_d = EXT;
          else                    make_vld = 1'b1;
        end
        BREAK:   state_d = IDLE;
        EXT:     state_d = (code == 8'hF0) ? BREAK : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blink_q <= '0;
    else        blink_q <= blink_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      buf_q      <= '0;
      move_ready <= 1'b0;
      move_out   <= '0;
      entry_err  <= 1'b0;
    end else begin
      entry_err <= 1'b0;
      if (move_ready) begin
        // Locked until acked; a code arriving with the ack is still dropped.
        if (move_ack) begin
          move_ready <= 1'b0;
          count_q    <= '0;
          buf_q      <= '0;
        end
      end else if (make_vld) begin
        if (is_char) begin
          if (!full) begin
            if (key.is_rank == count_q[0]) begin
              for (int i = 0; i < DIGITS; i++)
                if (CW'(i) == count_q) buf_q[i] <= key;
              count_q <= count_q + CW'(1);
            end else begin
              entry_err <= 1'b1;
            end
          end
        end else if (code == 8'h66) begin
          if (count_q != '0) begin
            for (int i = 0; i < DIGITS; i++)
              if (CW'(i) == count_q - CW'(1)) buf_q[i] <= '0;
            count_q <= count_q - CW'(1);
          end
        end else if (code == 8'h76) begin
          count_q <= '0;
          buf_q   <= '0;
        end else if (code == 8'h5A && full) begin
          move_ready <= 1'b1;
          move_out   <= buf_q;
        end
      end
    end
  end

  always_comb begin
    seg_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (CW'(i) < count_q)
        seg_d[7*i +: 7] = glyph(buf_q[i]);
      else if (CW'(i) == count_q && !move_ready && blink_q[BLINK_BITS-1])
        seg_d[7*i +: 7] = SEG_CURSOR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seg_out <= '1;
    else        seg_out <= seg_d;
  end

endmodule

// File: tb/tb_move_entry_display.sv
// Scoreboarded bench for move_entry_display: ready/err events checked by a monitor, display checked directly.
module tb_move_entry_display;

  localparam logic [6:0] G_BL = 7'b1111111;
  localparam logic [6:0] G_CU = 7'b1110111;
  localparam logic [6:0] G_A  = 7'b0001000;
  localparam logic [6:0] G_E  = 7'b0000110;
  localparam logic [6:0] G_H  = 7'b0001001;
  localparam logic [6:0] G_1  = 7'b1111001;
  localparam logic [6:0] G_2  = 7'b0100100;
  localparam logic [6:0] G_4  = 7'b0011001;
  localparam logic [6:0] G_8  = 7'b0000000;

  logic        clk, rst_n, code_valid, move_ack;
  logic [7:0]  code;
  logic        a_ready, a_err, b_ready, b_err;
  logic [15:0] a_move, b_move;
  logic [27:0] a_seg, b_seg;

  typedef struct {
    bit          is_ready;
    logic [15:0] mv;
    logic [27:0] sg;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_pass = 0;
  bit rdy_prev = 0;

  move_entry_display dut_a (
    .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code(code),
    .move_ready(a_ready), .move_ack(move_ack), .move_out(a_move),
    .entry_err(a_err), .seg_out(a_seg)
  );

  move_entry_display #(.DIGITS(4), .BLINK_BITS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code(code),
    .move_ready(b_ready), .move_ack(move_ack), .move_out(b_move),
    .entry_err(b_err), .seg_out(b_seg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [27:0] seg4(input logic [6:0] d3, input logic [6:0] d2,
                                       input logic [6:0] d1, input logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic strobe(input logic [7:0] c);
    code_valid = 1'b1;
    code       = c;
    @(posedge clk); #1;
    code_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_ready = 1'b0; e.mv = '0; e.sg = '0;
    sb.push_back(e);
  endtask

  task automatic expect_ready(input logic [15:0] mv, input logic [27:0] sg);
    exp_t e;
    e.is_ready = 1'b1; e.mv = mv; e.sg = sg;
    sb.push_back(e);
  endtask

  // Monitor: each err pulse or ready rising edge consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      rdy_prev = 1'b0;
    end else begin
      if (a_err) begin
        n_chk++;
        if (sb.size() == 0) begin
          $display("FAIL err_unexpected: entry_err=1 with nothing expected");
        end else begin
          n_chk--;
          e = sb.pop_front();
          check("err_kind", {31'd0, e.is_ready}, 32'd0);
        end
      end
      if (a_ready && !rdy_prev) begin
        n_chk++;
        if (sb.size() == 0) begin
          $display("FAIL ready_unexpected: move_ready rose with nothing expected, move_out=%h", a_move);
        end else begin
          n_chk--;
          e = sb.pop_front();
          check("ready_kind", {31'd0, e.is_ready}, 32'd1);
          check("ready_move_out", {16'd0, a_move}, {16'd0, e.mv});
          check("ready_seg", {4'd0, a_seg}, {4'd0, e.sg});
        end
      end
      rdy_prev = a_ready;
    end
  end

  initial begin
    int lit;
    rst_n = 1'b0; code_valid = 1'b0; code = 8'h00; move_ack = 1'b0;
    #12;
    check("rst_ready", {31'd0, a_ready}, 32'd0);
    check("rst_err", {31'd0, a_err}, 32'd0);
    check("rst_move_out", {16'd0, a_move}, 32'd0);
    check("rst_seg_a", {4'd0, a_seg}, {4'd0, 28'hFFFFFFF});
    check("rst_seg_b", {4'd0, b_seg}, {4'd0, 28'hFFFFFFF});
    @(posedge clk); #1;
    rst_n = 1'b1;

    // E2E4 -> ready
    expect_ready(16'hB494, seg4(G_4, G_E, G_2, G_E));
    strobe(8'h24); strobe(8'h1E); strobe(8'h24); strobe(8'h25); strobe(8'h5A);
    idle(2);
    check("e2e4_ready", {31'd0, a_ready}, 32'd1);

    // Locked while ready
    strobe(8'h1C);
    idle(2);
    check("locked_ready", {31'd0, a_ready}, 32'd1);
    check("locked_move", {16'd0, a_move}, 32'h0000B494);
    check("locked_seg", {4'd0, a_seg}, {4'd0, seg4(G_4, G_E, G_2, G_E)});

    // Ack with a coincident code: code dropped, buffer cleared, move_out retained
    code_valid = 1'b1; code = 8'h1C; move_ack = 1'b1;
    @(posedge clk); #1;
    code_valid = 1'b0; move_ack = 1'b0;
    idle(2);
    check("ack_ready", {31'd0, a_ready}, 32'd0);
    check("ack_move_kept", {16'd0, a_move}, 32'h0000B494);
    check("ack_seg_blank", {4'd0, a_seg}, {4'd0, 28'hFFFFFFF});

    // E0 F0 5A: extended break swallows 5A; ack while idle is harmless
    strobe(8'hE0); strobe(8'hF0); strobe(8'h5A);
    move_ack = 1'b1; @(posedge clk); #1; move_ack = 1'b0;
    idle(2);
    check("ext_ready", {31'd0, a_ready}, 32'd0);
    check("ext_seg", {4'd0, a_seg}, {4'd0, 28'hFFFFFFF});

    // Break sequence does not duplicate the character
    strobe(8'h24); strobe(8'hF0); strobe(8'h24);
    idle(2);
    check("break_count1", {4'd0, a_seg}, {4'd0, seg4(G_BL, G_BL, G_BL, G_E)});
    strobe(8'h1E);
    idle(2);
    check("break_then_rank", {4'd0, a_seg}, {4'd0, seg4(G_BL, G_BL, G_2, G_E)});
    strobe(8'h76);
    idle(2);
    check("escape_clear", {4'd0, a_seg}, {4'd0, 28'hFFFFFFF});

    // Wrong class at count 0, then backspace at count 0
    expect_err();
    strobe(8'h16);
    idle(2);
    check("err_count0", {4'd0, a_seg}, {4'd0, 28'hFFFFFFF});
    check("err_pulse_done", {31'd0, a_err}, 32'd0);
    strobe(8'h66);
    idle(2);
    check("bksp_count0", {4'd0, a_seg}, {4'd0, 28'hFFFFFFF});

    // Backspace from count 2, cursor on digit1
    strobe(8'h24); strobe(8'h1E); strobe(8'h66);
    idle(2);
    check("bksp_seg_a", {4'd0, a_seg}, {4'd0, seg4(G_BL, G_BL, G_BL, G_E)});
    lit = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (b_seg[13:7] == G_CU) lit++;
    end
    check("cursor_d1_lit", lit, 4);
    check("cursor_d0_glyph", {25'd0, b_seg[6:0]}, {25'd0, G_E});
    check("cursor_d23_blank", {18'd0, b_seg[27:14]}, {18'd0, G_BL, G_BL});
    strobe(8'h76);
    idle(2);
    check("bksp_escape", {4'd0, a_seg}, {4'd0, 28'hFFFFFFF});

    // A1H8 with early enter, wrong class at count 2, overflow char, then ack
    strobe(8'h1C); strobe(8'h16); strobe(8'h5A);
    expect_err();
    strobe(8'h3E);
    strobe(8'h33); strobe(8'h3E);
    strobe(8'h1C);
    idle(2);
    check("full_not_ready", {31'd0, a_ready}, 32'd0);
    expect_ready(16'hF780, seg4(G_8, G_H, G_1, G_A));
    strobe(8'h5A);
    idle(2);
    check("a1h8_ready", {31'd0, a_ready}, 32'd1);
    move_ack = 1'b1; @(posedge clk); #1; move_ack = 1'b0;
    check("a1h8_ack", {31'd0, a_ready}, 32'd0);

    // Async reset mid-entry, then blink phase on the short-counter instance
    strobe(8'h24);
    idle(2);
    check("pre_rst_seg", {25'd0, a_seg[6:0]}, {25'd0, G_E});
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_seg_a", {4'd0, a_seg}, {4'd0, 28'hFFFFFFF});
    check("arst_seg_b", {4'd0, b_seg}, {4'd0, 28'hFFFFFFF});
    check("arst_move", {16'd0, a_move}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      check($sformatf("blink_d0_k%0d", k), {25'd0, b_seg[6:0]},
            {25'd0, ((((k - 1) % 8) >= 4) ? G_CU : G_BL)});
    end
    strobe(8'h5A);
    idle(2);
    check("post_rst_no_move", {31'd0, a_ready}, 32'd0);

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
